// File: rtl/usb_rx_wire_sampler.sv
// USB receive front end: two-flop pin synchroniser, edge-realigned bit phase counter,
// one {D+,D-} sample + strobe per bit period. Optional stability filter: USB_RX_GLITCH_FILTER_EN.
module usb_rx_wire_sampler #(
    parameter int FS_DIV = 4,
    parameter int LS_DIV = 32,
    parameter int CNT_W  = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       usbDp,
    input  logic       usbDm,
    input  logic       fullSpeedRate,
    output logic [1:0] RxWireDataOut,
    output logic       RxWireDataWEn
);

    // Terminal and mid-bit counts kept separately so LS_DIV == 2**CNT_W still works.
    localparam logic [CNT_W-1:0] FS_LAST = CNT_W'(FS_DIV - 1);
    localparam logic [CNT_W-1:0] FS_HALF = CNT_W'(FS_DIV / 2);
    localparam logic [CNT_W-1:0] LS_LAST = CNT_W'(LS_DIV - 1);
    localparam logic [CNT_W-1:0] LS_HALF = CNT_W'(LS_DIV / 2);

    typedef enum logic {ST_FILL, ST_RUN} state_t;

    state_t           state, stateNext;
    logic [1:0]       fillCnt, fillCntNext;
    logic             dpS1, dpS2, dmS1, dmS2;
    logic [1:0]       lineSync, lineCur, lineSyncPrev;
    logic             rateReg;
    logic [CNT_W-1:0] phaseCnt, phaseNext, divLast, divHalf;
    logic             edgeDet, rateChg, sampleHit;

    assign lineSync = {dpS2, dmS2};

    always_ff @(posedge clk) begin
        if (rst) begin
            dpS1 <= 1'b0;
            dpS2 <= 1'b0;
            dmS1 <= 1'b0;
            dmS2 <= 1'b0;
        end else begin
            dpS1 <= usbDp;
            dpS2 <= dpS1;
            dmS1 <= usbDm;
            dmS2 <= dmS1;
        end
    end

`ifdef USB_RX_GLITCH_FILTER_EN
    // First stage equal to second stage means the synchronised value has held two cycles;
    // comparing here rather than after lineSync keeps the added latency to one clk.
    logic [1:0] lineFilt;

    always_ff @(posedge clk) begin
        if (rst)
            lineFilt <= 2'b00;
        else if ({dpS1, dmS1} == lineSync)
            lineFilt <= lineSync;
    end

    assign lineCur = lineFilt;
`else
    assign lineCur = lineSync;
`endif

    assign edgeDet = (lineCur != lineSyncPrev);
    assign rateChg = (rateReg != fullSpeedRate);
    assign divLast = rateReg ? FS_LAST : LS_LAST;
    assign divHalf = rateReg ? FS_HALF : LS_HALF;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_FILL;
            fillCnt       <= 2'd0;
            phaseCnt      <= '0;
            lineSyncPrev  <= 2'b00;
            rateReg       <= 1'b0;
            RxWireDataOut <= 2'b00;
            RxWireDataWEn <= 1'b0;
        end else begin
            state         <= stateNext;
            fillCnt       <= fillCntNext;
            phaseCnt      <= phaseNext;
            lineSyncPrev  <= lineCur;
            rateReg       <= fullSpeedRate;
            RxWireDataWEn <= sampleHit;
            if (sampleHit)
                RxWireDataOut <= lineCur;
        end
    end

    always_comb begin
        stateNext   = state;
        fillCntNext = fillCnt;
        phaseNext   = phaseCnt;
        sampleHit   = 1'b0;
        case (state)
            ST_FILL: begin
                phaseNext = '0;
                if (fillCnt == 2'd2) begin
                    stateNext   = ST_RUN;
                    fillCntNext = 2'd0;
                end else begin
                    fillCntNext = fillCnt + 2'd1;
                end
            end
            ST_RUN: begin
                // Edges and rate changes realign the bit phase and win over a mid-bit sample.
                sampleHit = (phaseCnt == divHalf) && !edgeDet && !rateChg;
                if (rateChg || edgeDet)
                    phaseNext = '0;
                else if (phaseCnt == divLast)
                    phaseNext = '0;
                else
                    phaseNext = phaseCnt + CNT_W'(1);
            end
            default: stateNext = ST_FILL;
        endcase
    end

endmodule
